// File: rtl/mc_pkg.sv
//------------------------------------------------------------------------------
// mc_pkg : shared encodings for the multi-cycle MIPS-subset controller
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_ori   = 6'h0d;
   localparam logic [5:0] c_op_lui   = 6'h0f;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2b;

   localparam logic [5:0] c_fn_nop   = 6'h00;
   localparam logic [5:0] c_fn_jr    = 6'h08;
   localparam logic [5:0] c_fn_addu  = 6'h21;
   localparam logic [5:0] c_fn_subu  = 6'h23;

   localparam logic [2:0] c_alu_add  = 3'd0;
   localparam logic [2:0] c_alu_sub  = 3'd1;
   localparam logic [2:0] c_alu_or   = 3'd2;
   localparam logic [2:0] c_alu_lui  = 3'd3;

   localparam logic [1:0] c_rd_rt    = 2'd0;
   localparam logic [1:0] c_rd_rd    = 2'd1;
   localparam logic [1:0] c_rd_ra    = 2'd2;

   localparam logic [1:0] c_wd_alu   = 2'd0;
   localparam logic [1:0] c_wd_dm    = 2'd1;
   localparam logic [1:0] c_wd_pc    = 2'd2;

   localparam logic [1:0] c_pc_plus4 = 2'd0;
   localparam logic [1:0] c_pc_br    = 2'd1;
   localparam logic [1:0] c_pc_jmp   = 2'd2;
   localparam logic [1:0] c_pc_rs    = 2'd3;

   // One-hot instruction class; exactly one flag is set for any opcode/funct.
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic nop;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic ill;
   } iclass_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_if.sv
//------------------------------------------------------------------------------
// mc_ctrl_if : instruction fields in, control strobes/selects out
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mc_ctrl_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        pc_we;
   logic        ir_we;
   logic        rf_we;
   logic        dm_we;
   logic [2:0]  alu_ctrl;
   logic        alu_src_b;
   logic        ext_op;
   logic [1:0]  reg_dst;
   logic [1:0]  wd_sel;
   logic [1:0]  pc_sel;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] instr_cnt;

   modport master (
      output opcode, funct, zero,
      input  pc_we, ir_we, rf_we, dm_we, alu_ctrl, alu_src_b, ext_op,
             reg_dst, wd_sel, pc_sel, illegal, state, instr_cnt
   );

   modport slave (
      input  opcode, funct, zero,
      output pc_we, ir_we, rf_we, dm_we, alu_ctrl, alu_src_b, ext_op,
             reg_dst, wd_sel, pc_sel, illegal, state, instr_cnt
   );
endinterface

`default_nettype wire

// File: rtl/mc_decode.sv
//------------------------------------------------------------------------------
// mc_decode : combinational opcode/funct to one-hot instruction class
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_decode
   import mc_pkg::*;
(
   input  wire logic [5:0] opcode,
   input  wire logic [5:0] funct,
   output iclass_t         cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         c_op_rtype: begin
            case (funct)
               c_fn_addu: cls.addu = 1'b1;
               c_fn_subu: cls.subu = 1'b1;
               c_fn_jr:   cls.jr   = 1'b1;
               c_fn_nop:  cls.nop  = 1'b1;
               default:   cls.ill  = 1'b1;
            endcase
         end
         c_op_ori: cls.ori = 1'b1;
         c_op_lui: cls.lui = 1'b1;
         c_op_lw:  cls.lw  = 1'b1;
         c_op_sw:  cls.sw  = 1'b1;
         c_op_beq: cls.beq = 1'b1;
         c_op_j:   cls.j   = 1'b1;
         c_op_jal: cls.jal = 1'b1;
         default:  cls.ill = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
//------------------------------------------------------------------------------
// mc_ctrl : multi-cycle controller FSM with retired-instruction counter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl
   import mc_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  reset,
   mc_ctrl_if.slave   bus
);

   iclass_t     w_cls;
   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cnt;
   logic        w_retire;
   logic        w_pc_we, w_ir_we, w_rf_we, w_dm_we, w_illegal;
   logic [2:0]  w_alu_ctrl;
   logic        w_alu_src_b, w_ext_op;
   logic [1:0]  w_reg_dst, w_wd_sel, w_pc_sel;
   logic [2:0]  w_dp_alu;
   logic        w_dp_src_b, w_dp_ext;
   logic [1:0]  w_dp_reg_dst, w_dp_wd_sel;

   mc_decode u_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .cls    (w_cls)
   );

   // Datapath selects depend only on the instruction, so they stay put EXEC..WB.
   always_comb begin
      w_dp_alu     = c_alu_add;
      w_dp_src_b   = 1'b0;
      w_dp_ext     = 1'b0;
      w_dp_reg_dst = (w_cls.addu | w_cls.subu) ? c_rd_rd : c_rd_rt;
      w_dp_wd_sel  = w_cls.lw ? c_wd_dm : c_wd_alu;
      if (w_cls.subu) w_dp_alu = c_alu_sub;
      if (w_cls.ori) begin
         w_dp_alu   = c_alu_or;
         w_dp_src_b = 1'b1;
      end
      if (w_cls.lui) begin
         w_dp_alu   = c_alu_lui;
         w_dp_src_b = 1'b1;
      end
      if (w_cls.lw | w_cls.sw) begin
         w_dp_src_b = 1'b1;
         w_dp_ext   = 1'b1;
      end
      if (w_cls.beq) begin
         w_dp_alu = c_alu_sub;
         w_dp_ext = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = S_FETCH;
      w_retire    = 1'b0;
      w_pc_we     = 1'b0;
      w_ir_we     = 1'b0;
      w_rf_we     = 1'b0;
      w_dm_we     = 1'b0;
      w_illegal   = 1'b0;
      w_alu_ctrl  = c_alu_add;
      w_alu_src_b = 1'b0;
      w_ext_op    = 1'b0;
      w_reg_dst   = c_rd_rt;
      w_wd_sel    = c_wd_alu;
      w_pc_sel    = c_pc_plus4;
      case (r_state)
         S_FETCH: begin
            w_ir_we = 1'b1;
            w_pc_we = 1'b1;
            w_next  = S_DECODE;
         end
         S_DECODE: begin
            if (w_cls.j | w_cls.jal) begin
               w_pc_we  = 1'b1;
               w_pc_sel = c_pc_jmp;
               w_retire = 1'b1;
               if (w_cls.jal) begin
                  w_rf_we   = 1'b1;
                  w_reg_dst = c_rd_ra;
                  w_wd_sel  = c_wd_pc;
               end
            end else if (w_cls.jr) begin
               w_pc_we  = 1'b1;
               w_pc_sel = c_pc_rs;
               w_retire = 1'b1;
            end else if (w_cls.nop) begin
               w_retire = 1'b1;
            end else if (w_cls.ill) begin
               w_illegal = 1'b1;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC, S_MEM, S_WB: begin
            w_alu_ctrl  = w_dp_alu;
            w_alu_src_b = w_dp_src_b;
            w_ext_op    = w_dp_ext;
            w_reg_dst   = w_dp_reg_dst;
            w_wd_sel    = w_dp_wd_sel;
            if (r_state == S_EXEC) begin
               if (w_cls.beq) begin
                  w_pc_we  = bus.zero;
                  w_pc_sel = c_pc_br;
                  w_retire = 1'b1;
               end else if (w_cls.lw | w_cls.sw) begin
                  w_next = S_MEM;
               end else begin
                  w_next = S_WB;
               end
            end else if (r_state == S_MEM) begin
               if (w_cls.sw) begin
                  w_dm_we  = 1'b1;
                  w_retire = 1'b1;
               end else begin
                  w_next = S_WB;
               end
            end else begin
               w_rf_we  = 1'b1;
               w_retire = 1'b1;
            end
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_cnt <= '0;
      else if (w_retire) r_cnt <= r_cnt + 32'd1;
   end

   // Strobes are masked by reset so an async assert kills them within the cycle.
   assign bus.pc_we     = w_pc_we   & ~reset;
   assign bus.ir_we     = w_ir_we   & ~reset;
   assign bus.rf_we     = w_rf_we   & ~reset;
   assign bus.dm_we     = w_dm_we   & ~reset;
   assign bus.illegal   = w_illegal & ~reset;
   assign bus.alu_ctrl  = w_alu_ctrl;
   assign bus.alu_src_b = w_alu_src_b;
   assign bus.ext_op    = w_ext_op;
   assign bus.reg_dst   = w_reg_dst;
   assign bus.wd_sel    = w_wd_sel;
   assign bus.pc_sel    = w_pc_sel;
   assign bus.state     = r_state;
   assign bus.instr_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-004 SHALL have port: funct  input  6  IR[5:0].
REQ-005 SHALL have port: zero  input  1  ALU equality flag, sampled in EXEC.
REQ-006 SHALL have port: pc_we  output  1  PC load strobe.
REQ-007 SHALL have port: ir_we  output  1  instruction register load strobe.
REQ-008 SHALL have port: rf_we  output  1  register file write strobe.
REQ-009 SHALL have port: dm_we  output  1  data memory write strobe.
REQ-010 SHALL have port: alu_ctrl  output  3  0 ADD, 1 SUB, 2 OR, 3 LUI (B<<16).
REQ-011 SHALL have port: alu_src_b  output  1  0 register B, 1 extended immediate.
REQ-012 SHALL have port: ext_op  output  1  0 zero-extend, 1 sign-extend.
REQ-013 SHALL have port: reg_dst  output  2  0 rt, 1 rd, 2 $31.
REQ-014 SHALL have port: wd_sel  output  2  0 ALU result, 1 DM data, 2 PC register.
REQ-015 SHALL have port: pc_sel  output  2  0 PC+4, 1 branch target, 2 jump target, 3 rs.
REQ-016 SHALL have port: illegal  output  1  one-cycle pulse on unsupported instruction.
REQ-017 SHALL have port: state  output  3  current state code, for debug.
REQ-018 SHALL have port: instr_cnt  output  32  retired-instruction counter.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL return to FETCH on the next edge.
REQ-020 SHALL decode: R-type (opcode 0) addu funct 100001, subu 100011, jr 001000, nop (funct 000000); ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011; anything else is illegal.
REQ-021 FETCH SHALL assert ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
REQ-022 DECODE: j SHALL assert pc_we, pc_sel=2; jal SHALL additionally assert rf_we, reg_dst=2, wd_sel=2; jr SHALL assert pc_we, pc_sel=3; nop takes no action; all four SHALL return to FETCH (2-cycle instructions).
REQ-023 DECODE with an illegal instruction SHALL pulse illegal for that cycle, assert no strobe, and return to FETCH.
REQ-024 DECODE with any other legal instruction SHALL go to EXEC.
REQ-025 EXEC alu_ctrl/alu_src_b/ext_op SHALL be: addu 0/0/x, subu 1/0/x, ori 2/1/0, lui 3/1/0, lw and sw 0/1/1, beq 1/0/1.
REQ-026 EXEC with beq SHALL assert pc_we=zero, pc_sel=1, then go to FETCH (3 cycles).
REQ-027 EXEC with lw or sw SHALL go to MEM; with addu, subu, ori or lui it SHALL go to WB.
REQ-028 MEM with sw SHALL assert dm_we and go to FETCH (4 cycles); with lw it SHALL go to WB.
REQ-029 WB SHALL assert rf_we, with reg_dst=1 for R-type and 0 otherwise, and wd_sel=1 for lw and 0 otherwise, then go to FETCH (lw 5 cycles, ALU ops 4 cycles).
REQ-030 Control outputs SHALL be combinational from state, opcode, funct and zero; in any state not listed, strobes SHALL be 0 and selects SHALL be 0.
REQ-031 Datapath selects (alu_ctrl, alu_src_b, ext_op, reg_dst, wd_sel) SHALL be held stable from EXEC through WB.
REQ-032 instr_cnt SHALL increment by 1 on the final cycle of each legal instruction, including nop and a not-taken beq; it SHALL wrap from 0xFFFFFFFF to 0; illegal instructions SHALL NOT be counted.

Reset
REQ-033 Reset assertion SHALL immediately force state=FETCH and instr_cnt=0, independent of clk.
REQ-034 While reset is high, pc_we, ir_we, rf_we, dm_we and illegal SHALL be 0, including reset asserted mid-instruction.
REQ-035 After reset deasserts, the first rising edge SHALL execute FETCH.

Structure
REQ-036 A shared package mc_pkg SHALL hold the state encodings, opcode and funct constants, and the alu_ctrl, reg_dst, wd_sel and pc_sel codes.
REQ-037 Instruction classification SHALL live in one combinational sub-module, mc_decode, which produces one-hot class flags from opcode and funct.

Verification
REQ-038 Reset, then apply addu (op 0, funct 21h) -> states 0,1,2,4,0; rf_we=1 with reg_dst=1 in WB; instr_cnt=1.
REQ-039 Apply lw (op 23h) -> 5 cycles; WB has wd_sel=1; apply sw (op 2Bh) -> dm_we=1 only in MEM.
REQ-040 Apply beq with zero=1 -> pc_we=1, pc_sel=1 in EXEC; apply beq with zero=0 -> pc_we=0, count still increments.
REQ-041 Apply jal -> in DECODE pc_we=1, pc_sel=2, rf_we=1, reg_dst=2, wd_sel=2; next state FETCH.
REQ-042 Apply opcode 3Fh -> illegal high for one cycle in DECODE, no strobes, instr_cnt unchanged.
REQ-043 Assert reset asynchronously in MEM of sw -> dm_we drops immediately, state=0, instr_cnt=0.
